// File: rtl/param_stream_mux_pkg.sv
// Shared types and constants for the packet-stream multiplexer.
package param_stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin search: first valid channel at or above rr_ptr, wrapping modulo N.
module rr_arbiter_n #(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     in_valid,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_found
);

    logic [SEL_W-1:0] w_idx;

    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        w_idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = SEL_W'((32'(rr_ptr) + i) % N);
            if (!grant_found && in_valid[w_idx]) begin
                grant_found = 1'b1;
                grant_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/param_stream_mux.sv
// N-channel packet-stream mux: one arbitration cycle in IDLE, then the channel is locked until
// its last beat; a single registered output stage carries the beat downstream.
module param_stream_mux
    import param_stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               busy
);

    state_e           r_state;
    logic [SEL_W-1:0] r_cur_sel;
    logic [SEL_W-1:0] r_rr_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;

    logic [WIDTH-1:0] w_ch_data [N];
    logic [SEL_W-1:0] w_arb_idx;
    logic             w_arb_found;
    logic [SEL_W-1:0] w_cand;
    logic             w_cand_ok;
    logic             w_can_take;
    logic             w_accept;
    logic [SEL_W-1:0] w_next_ptr;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign w_ch_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    rr_arbiter_n #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .in_valid    (in_valid),
        .rr_ptr      (r_rr_ptr),
        .grant_idx   (w_arb_idx),
        .grant_found (w_arb_found)
    );

    // An out-of-range fixed select yields no candidate, so the block idles.
    always_comb begin
        w_cand    = '0;
        w_cand_ok = 1'b0;
        unique case (mode)
            MODE_FIXED: begin
                w_cand    = sel;
                w_cand_ok = (32'(sel) < N) && in_valid[sel];
            end
            MODE_RR: begin
                w_cand    = w_arb_idx;
                w_cand_ok = w_arb_found;
            end
        endcase
    end

    // The output slot is free when empty or draining this cycle.
    always_comb begin
        w_can_take = (r_state == LOCKED) && (!r_out_valid || out_ready);
        w_accept   = w_can_take && in_valid[r_cur_sel];
        w_next_ptr = (32'(r_cur_sel) == N - 1) ? '0 : r_cur_sel + 1'b1;
        in_ready   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            in_ready[k] = w_can_take && (r_cur_sel == SEL_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cur_sel <= '0;
            r_rr_ptr  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_cand_ok) begin
                        r_state   <= LOCKED;
                        r_cur_sel <= w_cand;
                    end
                end
                LOCKED: begin
                    if (w_accept && in_last[r_cur_sel]) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= w_ch_data[r_cur_sel];
            r_out_last  <= in_last[r_cur_sel];
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign cur_sel   = r_cur_sel;
    assign busy      = (r_state == LOCKED);

endmodule

// File: tb/tb_param_stream_mux.sv
// Scoreboard bench for param_stream_mux: per-channel beat sources, an ordered expectation queue
// and a monitor that checks every output transfer plus one-cycle acceptance latency.
module tb_param_stream_mux;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    logic            clk;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [SW-1:0]   sel;
    logic            mode;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;
    logic [SW-1:0]   cur_sel;
    logic            busy;

    logic [3*W-1:0]  d3_in_data;
    logic [2:0]      d3_in_valid;
    logic [2:0]      d3_in_last;
    logic [2:0]      d3_in_ready;
    logic [1:0]      d3_sel;
    logic            d3_mode;
    logic [W-1:0]    d3_out_data;
    logic            d3_out_valid;
    logic            d3_out_last;
    logic            d3_out_ready;
    logic [1:0]      d3_cur_sel;
    logic            d3_busy;

    // Beat encoding in all queues: {last, data[7:0]}.
    logic [8:0]      src_q [N][$];
    logic [8:0]      exp_q [$];
    int              acc_cyc [$];
    int              cyc;
    int              n_vec;
    int              n_err;

    param_stream_mux #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .cur_sel   (cur_sel),
        .busy      (busy)
    );

    param_stream_mux #(.WIDTH(W), .N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (d3_in_data),
        .in_valid  (d3_in_valid),
        .in_last   (d3_in_last),
        .in_ready  (d3_in_ready),
        .sel       (d3_sel),
        .mode      (d3_mode),
        .out_data  (d3_out_data),
        .out_valid (d3_out_valid),
        .out_last  (d3_out_last),
        .out_ready (d3_out_ready),
        .cur_sel   (d3_cur_sel),
        .busy      (d3_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit src_busy();
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || src_busy()) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Sources: a head beat is popped once the edge it was accepted on has passed.
    initial begin
        logic [N-1:0] sacc;
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            sacc = in_valid & in_ready;
            @(posedge clk);
            if (!rst_n) sacc = '0;
            #1;
            for (int k = 0; k < N; k++) begin
                if (sacc[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
                if (src_q[k].size() != 0) begin
                    in_valid[k]        = 1'b1;
                    in_last[k]         = src_q[k][0][8];
                    in_data[k*W +: W]  = src_q[k][0][7:0];
                end else begin
                    in_valid[k]        = 1'b0;
                    in_last[k]         = 1'b0;
                    in_data[k*W +: W]  = '0;
                end
            end
        end
    end

    // Monitor: ordered scoreboard on transfers, and each accepted beat must be on out_* next cycle.
    initial begin
        logic [N-1:0] macc;
        logic [8:0]   pend;
        logic [8:0]   e;
        bit           pend_v;
        pend_v = 1'b0;
        pend   = '0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_beat: got 0x%0h, required no beat (cycle %0d)",
                             {out_last, out_data}, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", 32'({out_last, out_data}), 32'(e));
                end
            end
            if (!rst_n) begin
                pend_v = 1'b0;
            end else begin
                if (pend_v) begin
                    check("lat_valid", 32'(out_valid), 32'd1);
                    check("lat_beat", 32'({out_last, out_data}), 32'(pend));
                end
                macc   = in_valid & in_ready;
                pend_v = (macc != '0);
                for (int k = 0; k < N; k++) begin
                    if (macc[k]) pend = {in_last[k], in_data[k*W +: W]};
                end
                if (pend_v) acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic push(input int ch, input logic [8:0] beat);
        src_q[ch].push_back(beat);
    endtask

    initial begin
        int t;
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b1;
        mode         = 1'b0;
        sel          = '0;
        out_ready    = 1'b1;
        d3_mode      = 1'b0;
        d3_sel       = 2'd3;
        d3_in_valid  = 3'b111;
        d3_in_last   = 3'b111;
        d3_in_data   = 24'hC2B1A0;
        d3_out_ready = 1'b1;

        // Reset values
        #3 rst_n = 1'b0;
        #14;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_cur_sel", 32'(cur_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: fixed pass-through on ch2
        tick();
        mode = 1'b0;
        sel  = 2'd2;
        acc_cyc.delete();
        push(2, 9'h0A1); push(2, 9'h0A2); push(2, 9'h1A3);
        exp_q.push_back(9'h0A1); exp_q.push_back(9'h0A2); exp_q.push_back(9'h1A3);
        wait_drain("t1_drain", 40);
        repeat (2) @(negedge clk);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_cur_sel", 32'(cur_sel), 32'd2);
        check("t1_accepts", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            check("t1_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
            check("t1_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
        end

        // 2: select change mid-packet is ignored until the last beat
        tick();
        sel = 2'd1;
        acc_cyc.delete();
        push(1, 9'h0B1); push(1, 9'h0B2); push(1, 9'h0B3); push(1, 9'h1B4);
        push(3, 9'h131);
        exp_q.push_back(9'h0B1); exp_q.push_back(9'h0B2);
        exp_q.push_back(9'h0B3); exp_q.push_back(9'h1B4);
        exp_q.push_back(9'h131);
        t = 0;
        while (acc_cyc.size() < 2 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("t2_two_beats", 32'(acc_cyc.size() >= 2), 32'd1);
        sel = 2'd3;
        wait_drain("t2_drain", 40);
        repeat (2) @(negedge clk);
        check("t2_accepts", 32'(acc_cyc.size()), 32'd5);
        if (acc_cyc.size() == 5) check("t2_arb_gap", 32'(acc_cyc[4] - acc_cyc[3]), 32'd2);
        check("t2_cur_sel", 32'(cur_sel), 32'd3);

        // 3: round-robin over four continuously valid channels, starting from rr_ptr=0
        tick();
        mode = 1'b1;
        acc_cyc.delete();
        push(0, 9'h110); push(0, 9'h110);
        push(1, 9'h111); push(2, 9'h112); push(3, 9'h113);
        exp_q.push_back(9'h110); exp_q.push_back(9'h111); exp_q.push_back(9'h112);
        exp_q.push_back(9'h113); exp_q.push_back(9'h110);
        wait_drain("t3_drain", 60);
        repeat (2) @(negedge clk);
        check("t3_accepts", 32'(acc_cyc.size()), 32'd5);
        if (acc_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) begin
                check("t3_idle_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
            end
        end

        // 4: backpressure holds the output and blocks acceptance
        tick();
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b0;
        push(0, 9'h055); push(0, 9'h156);
        exp_q.push_back(9'h055); exp_q.push_back(9'h156);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_data", 32'(out_data), 32'h55);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_release_data", 32'(out_data), 32'h55);
        @(negedge clk);
        check("t4_next_beat", 32'({out_valid, out_last, out_data}), 32'h356);
        wait_drain("t4_drain", 20);

        // 6: asynchronous reset during beat 2 of 4
        tick();
        mode = 1'b0;
        sel  = 2'd2;
        push(2, 9'h061); push(2, 9'h062); push(2, 9'h063); push(2, 9'h164);
        exp_q.push_back(9'h061); exp_q.push_back(9'h062);
        exp_q.push_back(9'h063); exp_q.push_back(9'h164);
        t = 0;
        while (!(out_valid && out_data == 8'h61) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t6_first_beat", 32'(out_data), 32'h61);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd0);
        check("t6_rst_cur_sel", 32'(cur_sel), 32'd0);
        for (int k = 0; k < N; k++) src_q[k].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        mode = 1'b1;
        push(0, 9'h170); push(1, 9'h171);
        exp_q.push_back(9'h170); exp_q.push_back(9'h171);
        wait_drain("t6_restart", 30);
        repeat (2) @(negedge clk);
        check("t6_cur_sel", 32'(cur_sel), 32'd1);

        // 5: N=3 instance with out-of-range fixed select never locks
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_in_ready", 32'(d3_in_ready), 32'd0);
            check("t5_out_valid", 32'(d3_out_valid), 32'd0);
            check("t5_busy", 32'(d3_busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
